// File: rtl/jtframe_colmix_pkg.sv
// Shared helpers for the N-layer colour mixer: index widths, palette byte
// packing for any channel depth, and the shadow colour code.
package jtframe_colmix_pkg;

    localparam logic [3:0] SHADOW_CODE = 4'hF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int idx_width(input int layers, input int pxlw);
        return clog2(layers) + pxlw;
    endfunction

    function automatic int pal_aw(input int layers, input int pxlw);
        return idx_width(layers, pxlw) + 1;
    endfunction

    // Narrow colours share the even byte as {R,G}. Wide colours keep the
    // top nibbles of G and B in the odd byte.
    function automatic rgb8_t pal_unpack(input logic [7:0] ev, input logic [7:0] od, input int colw);
        rgb8_t c;
        c = '0;
        if (colw <= 4) begin
            for (int i = 0; i < 8; i++) begin
                if (i < colw) begin
                    c.r[i] = ev[8-colw+i];
                    c.g[i] = ev[i];
                    c.b[i] = od[i];
                end
            end
        end else begin
            for (int i = 0; i < 8; i++)
                if (i < colw) c.r[i] = ev[i];
            for (int i = 0; i < 4; i++) begin
                c.g[colw-4+i] = od[4+i];
                c.b[colw-4+i] = od[i];
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] pal_pack(input rgb8_t c, input int colw);
        logic [7:0] ev, od;
        ev = '0;
        od = '0;
        if (colw <= 4) begin
            for (int i = 0; i < 8; i++) begin
                if (i < colw) begin
                    ev[8-colw+i] = c.r[i];
                    ev[i]        = c.g[i];
                    od[i]        = c.b[i];
                end
            end
        end else begin
            for (int i = 0; i < 8; i++)
                if (i < colw) ev[i] = c.r[i];
            for (int i = 0; i < 4; i++) begin
                od[4+i] = c.g[colw-4+i];
                od[i]   = c.b[colw-4+i];
            end
        end
        return {od, ev};
    endfunction

endpackage

// File: rtl/jtframe_colmix_prio.sv
// Layer priority encoder: picks the highest opaque enabled layer, detects shadow.
// Latency: combinational; registered by the parent.
// Backpressure: none, evaluated every cycle.
module jtframe_colmix_prio
    import jtframe_colmix_pkg::*;
#(
    parameter int LAYERS    = 4,
    parameter int PXLW      = 6,
    parameter int SHADOW_EN = 0,
    localparam int LW       = clog2(LAYERS),
    localparam int IDXW     = LW + PXLW
) (
    input  logic [LAYERS*PXLW-1:0] lyr_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    output logic [IDXW-1:0]        idx,
    output logic                   shadow
);

    always_comb begin
        shadow = (SHADOW_EN != 0) && gfx_en[LAYERS-1] &&
                 (lyr_pxl[(LAYERS-1)*PXLW +: 4] == SHADOW_CODE);
        // Background always resolves; a masked background points at entry 0.
        idx = gfx_en[0] ? {{LW{1'b0}}, lyr_pxl[PXLW-1:0]} : '0;
        for (int k = 1; k < LAYERS; k++) begin
            if (gfx_en[k] && lyr_pxl[k*PXLW +: 4] != 4'h0 && !(shadow && k == LAYERS-1))
                idx = {LW'(k), lyr_pxl[k*PXLW +: PXLW]};
        end
    end

endmodule

// File: rtl/jtframe_colmix_n.sv
// N-layer colour mixer: priority/transparency, palette lookup, shadow, blank gating.
// Latency: 3 pxl_cen from lyr_pxl to RGB; CPU read data 1 clk after access.
// Backpressure: none; video stalls only via pxl_cen, CPU port is never held off.
module jtframe_colmix_n
    import jtframe_colmix_pkg::*;
#(
    parameter int LAYERS    = 4,
    parameter int PXLW      = 6,
    parameter int COLW      = 4,
    parameter int SHADOW_EN = 0,
    localparam int IDXW     = idx_width(LAYERS, PXLW),
    localparam int PALAW    = pal_aw(LAYERS, PXLW)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] lyr_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic                   pal_cs,
    input  logic                   cpu_wrn,
    input  logic [PALAW-1:0]       cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [COLW-1:0]        red,
    output logic [COLW-1:0]        green,
    output logic [COLW-1:0]        blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly
);

    logic [IDXW-1:0] prio_idx, idx1;
    logic            prio_sh, sh1, sh2;
    logic [7:0]      pal_even [2**IDXW];
    logic [7:0]      pal_odd  [2**IDXW];
    logic [7:0]      vid_even, vid_odd;
    logic [2:0]      hbl_sr, vbl_sr;
    logic            cpu_we;
    logic [IDXW-1:0] cpu_ent;
    rgb8_t           col;
    logic            col_unused;

    jtframe_colmix_prio #(
        .LAYERS    (LAYERS),
        .PXLW      (PXLW),
        .SHADOW_EN (SHADOW_EN)
    ) u_prio (
        .lyr_pxl (lyr_pxl),
        .gfx_en  (gfx_en),
        .idx     (prio_idx),
        .shadow  (prio_sh)
    );

    assign cpu_we  = pal_cs && !cpu_wrn;
    assign cpu_ent = cpu_addr[PALAW-1:1];

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu_addr[0]) pal_odd[cpu_ent]  <= cpu_dout;
            else             pal_even[cpu_ent] <= cpu_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pal_dout <= '0;
        else if (pal_cs)
            pal_dout <= cpu_addr[0] ? pal_odd[cpu_ent] : pal_even[cpu_ent];
    end

    always_comb begin
        col        = pal_unpack(vid_even, vid_odd, COLW);
        col_unused = ^col;
    end

    // The blank gate looks at the stage-2 blank bit so RGB and *_dly leave together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx1     <= '0;
            sh1      <= 1'b0;
            sh2      <= 1'b0;
            vid_even <= '0;
            vid_odd  <= '0;
            hbl_sr   <= '0;
            vbl_sr   <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pxl_cen) begin
            idx1     <= prio_idx;
            sh1      <= prio_sh;
            vid_even <= pal_even[idx1];
            vid_odd  <= pal_odd[idx1];
            sh2      <= sh1;
            hbl_sr   <= {hbl_sr[1:0], LHBL};
            vbl_sr   <= {vbl_sr[1:0], LVBL};
            if (hbl_sr[1] && vbl_sr[1]) begin
                red   <= col.r[COLW-1:0] >> sh2;
                green <= col.g[COLW-1:0] >> sh2;
                blue  <= col.b[COLW-1:0] >> sh2;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    assign LHBL_dly = hbl_sr[2];
    assign LVBL_dly = vbl_sr[2];

endmodule

// File: tb/tb_jtframe_colmix_n.sv
// Bench for jtframe_colmix_n with LAYERS=4, PXLW=6, COLW=4, SHADOW_EN=1.
module tb_jtframe_colmix_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        LHBL = 1'b0, LVBL = 1'b0;
    logic [23:0] lyr_pxl = '0;
    logic [3:0]  gfx_en = '0;
    logic        pal_cs = 1'b0, cpu_wrn = 1'b1;
    logic [8:0]  cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  pal_dout;
    logic [3:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;

    int passed = 0;
    int total  = 0;
    logic [7:0] pal [512];

    jtframe_colmix_n #(.LAYERS(4), .PXLW(6), .COLW(4), .SHADOW_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .lyr_pxl(lyr_pxl), .gfx_en(gfx_en), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
        .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [23:0] px;
        logic [3:0]  en;
        logic        lh, lv;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick(input logic cen);
        pxl_cen = cen;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_addr = a; cpu_dout = d;
        tick(1'b0);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
        pal[a] = d;
    endtask

    function automatic logic [23:0] pk(input logic [5:0] l3, input logic [5:0] l2,
                                       input logic [5:0] l1, input logic [5:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: scan from the top layer down for the first visible one.
    function automatic logic [13:0] ref_px(input logic [23:0] px, input logic [3:0] en,
                                           input logic lh, input logic lv);
        int win, ent;
        bit shd;
        logic [7:0] ev, od;
        logic [3:0] r, g, b;
        shd = en[3] && (px[18 +: 4] == 4'hF);
        win = -1;
        for (int k = 3; k >= 1; k--)
            if (win < 0 && en[k] && px[k*6 +: 4] != 4'h0 && !(k == 3 && shd)) win = k;
        if (win < 0) ent = en[0] ? int'(px[5:0]) : 0;
        else         ent = win * 64 + int'(px[win*6 +: 6]);
        ev = pal[ent*2];
        od = pal[ent*2+1];
        r = ev[7:4]; g = ev[3:0]; b = od[3:0];
        if (shd) begin r = r / 2; g = g / 2; b = b / 2; end
        if (!(lh && lv)) begin r = 0; g = 0; b = 0; end
        return {lh, lv, r, g, b};
    endfunction

    function automatic logic [13:0] dut_out();
        return {LHBL_dly, LVBL_dly, red, green, blue};
    endfunction

    initial begin
        logic [13:0] q[$];
        logic [13:0] e;
        logic [12:0] hq[$];
        logic [12:0] he;
        bit primed;
        logic lh;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb", {LHBL_dly, LVBL_dly, red, green, blue}, 0);
        check("reset_pal_dout", pal_dout, 0);
        #2 rst_n = 1'b1;
        tick(1'b0);

        cpu_wr(9'h0C4, 8'h35); cpu_wr(9'h0C5, 8'h07);
        cpu_wr(9'h002, 8'h12); cpu_wr(9'h003, 8'h03);
        cpu_wr(9'h000, 8'h9A); cpu_wr(9'h001, 8'h0B);
        cpu_wr(9'h00A, 8'hEE); cpu_wr(9'h00B, 8'h0E);
        cpu_wr(9'h1C6, 8'h48); cpu_wr(9'h1C7, 8'h0C);
        cpu_wr(9'h162, 8'h66); cpu_wr(9'h163, 8'h06);

        vecs[0]  = '{pk(6'h00, 6'h00, 6'h22, 6'h01), 4'hF, 1'b1, 1'b1, 12'h357};
        vecs[1]  = '{pk(6'h00, 6'h00, 6'h22, 6'h01), 4'hD, 1'b1, 1'b1, 12'h123};
        vecs[2]  = '{pk(6'h00, 6'h00, 6'h00, 6'h01), 4'hE, 1'b1, 1'b1, 12'h9AB};
        vecs[3]  = '{pk(6'h00, 6'h00, 6'h00, 6'h01), 4'hF, 1'b1, 1'b1, 12'h123};
        vecs[4]  = '{pk(6'h0F, 6'h00, 6'h00, 6'h05), 4'hF, 1'b1, 1'b1, 12'h777};
        vecs[5]  = '{pk(6'h0F, 6'h00, 6'h00, 6'h05), 4'h7, 1'b1, 1'b1, 12'hEEE};
        vecs[6]  = '{pk(6'h23, 6'h31, 6'h22, 6'h01), 4'hF, 1'b1, 1'b1, 12'h48C};
        vecs[7]  = '{pk(6'h23, 6'h31, 6'h22, 6'h01), 4'h7, 1'b1, 1'b1, 12'h666};
        vecs[8]  = '{pk(6'h0F, 6'h31, 6'h22, 6'h05), 4'hF, 1'b1, 1'b1, 12'h333};
        vecs[9]  = '{pk(6'h1F, 6'h00, 6'h00, 6'h05), 4'hF, 1'b1, 1'b1, 12'h777};
        vecs[10] = '{pk(6'h00, 6'h00, 6'h22, 6'h01), 4'hF, 1'b0, 1'b1, 12'h000};
        vecs[11] = '{pk(6'h00, 6'h00, 6'h22, 6'h01), 4'hF, 1'b1, 1'b0, 12'h000};
        vecs[12] = '{pk(6'h10, 6'h00, 6'h00, 6'h05), 4'hF, 1'b1, 1'b1, 12'hEEE};
        vecs[13] = '{pk(6'h00, 6'h00, 6'h22, 6'h01), 4'hE, 1'b1, 1'b1, 12'h357};

        for (int i = 0; i < 14; i++) begin
            lyr_pxl = vecs[i].px; gfx_en = vecs[i].en;
            LHBL = vecs[i].lh; LVBL = vecs[i].lv;
            repeat (3) tick(1'b1);
            check($sformatf("vec%0d_rgb", i), {red, green, blue}, vecs[i].rgb);
            check($sformatf("vec%0d_blank", i), {LHBL_dly, LVBL_dly}, {vecs[i].lh, vecs[i].lv});
        end

        // CPU write to entry 0x62 on the same edge the video reads it.
        lyr_pxl = vecs[0].px; gfx_en = 4'hF; LHBL = 1'b1; LVBL = 1'b1;
        tick(1'b1);
        pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_addr = 9'h0C4; cpu_dout = 8'h55;
        tick(1'b1);
        pal_cs = 1'b0; cpu_wrn = 1'b1;
        pal[9'h0C4] = 8'h55;
        tick(1'b1);
        check("collide_old", {red, green, blue}, 12'h357);
        repeat (3) tick(1'b1);
        check("collide_new", {red, green, blue}, 12'h557);
        pal_cs = 1'b1; cpu_addr = 9'h0C4;
        tick(1'b0);
        check("cpu_rd_even", pal_dout, 8'h55);
        pal_cs = 1'b0; cpu_addr = 9'h0C5;
        tick(1'b0);
        check("cpu_rd_hold", pal_dout, 8'h55);
        pal_cs = 1'b1;
        tick(1'b0);
        pal_cs = 1'b0;
        check("cpu_rd_odd", pal_dout, 8'h07);
        cpu_wr(9'h0C4, 8'h35);

        // Ten blanked pixels, cen every other clk, garbage on idle clks.
        hq.delete();
        primed = 0;
        he = '0;
        for (int i = 0; i < 30; i++) begin
            lh = !(i >= 10 && i < 20);
            lyr_pxl = vecs[0].px; gfx_en = 4'hF; LHBL = lh;
            tick(1'b1);
            hq.push_back({lh, lh ? 12'h357 : 12'h000});
            if (hq.size() == 3) begin
                he = hq.pop_front();
                primed = 1;
                check($sformatf("hblank_px%0d", i - 2), {LHBL_dly, red, green, blue}, he);
            end
            lyr_pxl = 24'($urandom); LHBL = 1'($urandom);
            tick(1'b0);
            if (primed) check($sformatf("hblank_hold%0d", i), {LHBL_dly, red, green, blue}, he);
        end

        // Asynchronous reset mid-line, then refill of the pipeline.
        lyr_pxl = vecs[0].px; gfx_en = 4'hF; LHBL = 1'b1; LVBL = 1'b1;
        repeat (3) tick(1'b1);
        check("pre_reset", dut_out(), 14'h3357);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out", dut_out(), 0);
        check("async_reset_pal", pal_dout, 0);
        tick(1'b1);
        check("reset_held", dut_out(), 0);
        #2 rst_n = 1'b1;
        tick(1'b1);
        check("post_reset_cen1", dut_out(), 0);
        tick(1'b1);
        check("post_reset_cen2", dut_out(), 0);
        tick(1'b1);
        check("post_reset_cen3", dut_out(), 14'h3357);

        // Random palette and random pixel stream against the reference model.
        for (int a = 0; a < 512; a++) cpu_wr(9'(a), 8'($urandom));
        q.delete();
        primed = 0;
        e = '0;
        for (int n = 0; n < 600; n++) begin
            logic [23:0] px;
            logic c;
            px = 24'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) px[k*6 +: 4] = 4'h0;
            if ($urandom_range(0, 3) == 0) px[18 +: 4] = 4'hF;
            lyr_pxl = px;
            gfx_en  = 4'($urandom);
            LHBL    = ($urandom_range(0, 7) != 0);
            LVBL    = ($urandom_range(0, 7) != 0);
            c       = 1'($urandom);
            tick(c);
            if (c) begin
                q.push_back(ref_px(px, gfx_en, LHBL, LVBL));
                if (q.size() == 3) begin
                    e = q.pop_front();
                    primed = 1;
                end
            end
            if (primed) check($sformatf("rand%0d", n), dut_out(), e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
